// File: rtl/tff_arb_pkg.sv
// Shared types and helpers for the toggle arbiter: FSM state enum,
// index-to-onehot decode and the round-robin winner pick.
package tff_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TOGGLE,
        HOLD
    } state_t;

    // Widest decode: 64 bank bits or 16 requesters; callers truncate.
    function automatic logic [63:0] onehot(input logic [6:0] idx);
        onehot = 64'd1 << idx;
    endfunction

    // First set bit of req at or after ptr, wrapping modulo n.
    function automatic logic [3:0] rr_pick(
        input logic [15:0] req,
        input logic [3:0]  ptr,
        input int          n
    );
        logic [3:0] k;
        logic       found;
        rr_pick = '0;
        found   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            k = 4'((int'(ptr) + i) % n);
            if (!found && i < n && req[k]) begin
                rr_pick = k;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/tff_bank.sv
// Bank of NBITS T flip-flops sharing clk/rst; q[i] flips when t_vec[i].
// Ports: clk, rst (async, active-low), t_vec[NBITS] in, q[NBITS] out.
module tff (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end
endmodule

module tff_bank #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBITS-1:0] t_vec,
    output logic [NBITS-1:0] q
);
    for (genvar i = 0; i < NBITS; i++) begin : g_bit
        tff u_tff (
            .clk (clk),
            .rst (rst),
            .t   (t_vec[i]),
            .q   (q[i])
        );
    end
endmodule

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter sharing one T flip-flop bank among NREQ requesters.
// Ports: clk, rst (async, active-low), req[NREQ], sel[NREQ*IDXW], clr,
//        gnt[NREQ], err, busy, q[NBITS], par.
// Option: define TFF_ARB_PARITY_EN to drive par = ^q (else par = 0).
module tff_toggle_arbiter
    import tff_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDXW  = (NBITS > 1) ? $clog2(NBITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*IDXW-1:0] sel,
    input  logic                 clr,
    output logic [NREQ-1:0]      gnt,
    output logic                 err,
    output logic                 busy,
    output logic [NBITS-1:0]     q,
    output logic                 par
);

    localparam int PTRW = $clog2(NREQ);

    state_t          state;
    logic [PTRW-1:0] ptr_q;
    logic [PTRW-1:0] win_q;
    logic [PTRW-1:0] w;
    logic [IDXW-1:0] idx_q;
    logic [IDXW-1:0] sel_w;
    logic [NBITS-1:0] t_vec;

    assign w = PTRW'(rr_pick(16'(req), 4'(ptr_q), NREQ));

    always_comb begin
        sel_w = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PTRW'(i) == w) begin
                sel_w = sel[i*IDXW +: IDXW];
            end
        end
    end

    // gnt/err are registered so they are high exactly in TOGGLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr_q <= '0;
            win_q <= '0;
            idx_q <= '0;
            gnt   <= '0;
            err   <= 1'b0;
        end else begin
            gnt <= '0;
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        win_q <= w;
                        idx_q <= sel_w;
                        gnt   <= NREQ'(onehot(7'(w)));
                        err   <= (32'(sel_w) >= NBITS);
                        state <= TOGGLE;
                    end
                end
                TOGGLE: begin
                    ptr_q <= (int'(win_q) == NREQ - 1) ? '0
                                                       : win_q + PTRW'(1);
                    state <= HOLD;
                end
                HOLD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // clr flips every set bit, which wins over the granted toggle.
    always_comb begin
        t_vec = '0;
        if (clr) begin
            t_vec = q;
        end else if (state == TOGGLE && !err) begin
            t_vec = NBITS'(onehot(7'(idx_q)));
        end
    end

    tff_bank #(
        .NBITS (NBITS)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .t_vec (t_vec),
        .q     (q)
    );

    assign busy = (state != IDLE);

`ifdef TFF_ARB_PARITY_EN
    assign par = ^q;
`else
    assign par = 1'b0;
`endif

endmodule
